// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the MEM-stage access unit.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mem_access_unit_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam int WORD_BYTES = 4;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

endpackage

// File: rtl/mem_access_unit_dmem_array.sv
// Word-wide data memory: synchronous write, asynchronous read.
// Latency: write lands on the clock edge; read data follows the address combinationally.
// Backpressure: none; always ready.
module dmem_array
    import mem_access_unit_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Single write port; contents deliberately have no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit with WAIT_CYCLES wait states, MEM/WB output registers.
// Latency: 1 cycle for non-memory ops, WAIT_CYCLES+1 cycles for loads/stores.
// Backpressure: stall held high for exactly WAIT_CYCLES cycles per access. Optional: MISALIGN_TRAP_EN.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int AW          = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [DATA_W-1:0]     mem_Alu_Result,
    input  logic [DATA_W-1:0]     mem_rb,
    input  logic                  mem_wmem,
    input  logic                  mem_m2reg,
    input  logic                  mem_wreg,
    input  logic [REG_ADDR_W-1:0] mem_rn,
    output logic                  stall,
    output logic [DATA_W-1:0]     wb_Alu_Result,
    output logic [DATA_W-1:0]     wb_mem_data,
    output logic                  wb_m2reg,
    output logic                  wb_wreg,
    output logic [REG_ADDR_W-1:0] wb_rn,
`ifdef MISALIGN_TRAP_EN
    output logic                  misalign_err,
`endif
    output logic [DATA_W-1:0]     wb_result
);

    localparam logic [3:0] WAIT_M1 = 4'(WAIT_CYCLES - 1);

    state_t            state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic              req, is_load, done, misal, we;
    logic [DATA_W-1:0] rdata;

    assign req     = mem_wmem | mem_m2reg;
    // Store wins when both request bits are set.
    assign is_load = mem_m2reg & ~mem_wmem;

`ifdef MISALIGN_TRAP_EN
    assign misal = req & (mem_Alu_Result[1:0] != 2'b00);
`else
    assign misal = 1'b0;
`endif

    // Write only in the completion cycle, so a held store commits exactly once.
    assign we = done & mem_wmem & ~misal;

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_dmem (
        .clk   (clk),
        .we    (we),
        .addr  (mem_Alu_Result[AW+1:2]),
        .wdata (mem_rb),
        .rdata (rdata)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (clr) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state, stall and completion strobe; clr overrides everything.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        stall     = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    if (WAIT_CYCLES == 0 || misal) begin
                        done = 1'b1;
                    end else begin
                        stall     = 1'b1;
                        state_nxt = ST_BUSY;
                        cnt_nxt   = WAIT_M1;
                    end
                end
            end
            ST_BUSY: begin
                if (cnt != 4'd0) begin
                    stall   = 1'b1;
                    cnt_nxt = cnt - 4'd1;
                end else begin
                    done      = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (clr) begin
            stall     = 1'b0;
            done      = 1'b0;
            state_nxt = ST_IDLE;
            cnt_nxt   = 4'd0;
        end
    end

    // MEM/WB register: bubble while stalled, otherwise capture the instruction.
    always_ff @(posedge clk) begin
        if (clr) begin
            wb_Alu_Result <= '0;
            wb_mem_data   <= '0;
            wb_m2reg      <= 1'b0;
            wb_wreg       <= 1'b0;
            wb_rn         <= '0;
        end else if (stall) begin
            wb_m2reg <= 1'b0;
            wb_wreg  <= 1'b0;
        end else begin
            wb_Alu_Result <= mem_Alu_Result;
            wb_m2reg      <= is_load;
            wb_wreg       <= mem_wreg & ~misal;
            wb_rn         <= mem_rn;
            if (done && is_load) begin
                wb_mem_data <= rdata;
            end
        end
    end

`ifdef MISALIGN_TRAP_EN
    // One-cycle trap flag for a misaligned access.
    always_ff @(posedge clk) begin
        if (clr || stall) begin
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= misal;
        end
    end
`endif

    assign wb_result = wb_m2reg ? wb_mem_data : wb_Alu_Result;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: one zero-wait instance driven from a vector table,
// one two-wait-state instance driven by hand-written multi-cycle sequences.
// Optional misalignment checks follow MISALIGN_TRAP_EN.
module tb_mem_access_unit;

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // WAIT_CYCLES = 0 instance
    logic [31:0] a_addr, a_rb;
    logic        a_wmem, a_m2reg, a_wreg;
    logic [4:0]  a_rn;
    logic        a_stall, a_wb_m2reg, a_wb_wreg;
    logic [31:0] a_wb_alu, a_wb_mdata, a_wb_res;
    logic [4:0]  a_wb_rn;

    // WAIT_CYCLES = 2 instance
    logic [31:0] b_addr, b_rb;
    logic        b_wmem, b_m2reg, b_wreg;
    logic [4:0]  b_rn;
    logic        b_stall, b_wb_m2reg, b_wb_wreg;
    logic [31:0] b_wb_alu, b_wb_mdata, b_wb_res;
    logic [4:0]  b_wb_rn;

`ifdef MISALIGN_TRAP_EN
    logic a_merr, b_merr;
`endif

    mem_access_unit #(.DEPTH(256), .AW(8), .WAIT_CYCLES(0)) u0 (
        .clk(clk), .clr(clr),
        .mem_Alu_Result(a_addr), .mem_rb(a_rb), .mem_wmem(a_wmem),
        .mem_m2reg(a_m2reg), .mem_wreg(a_wreg), .mem_rn(a_rn),
        .stall(a_stall), .wb_Alu_Result(a_wb_alu), .wb_mem_data(a_wb_mdata),
        .wb_m2reg(a_wb_m2reg), .wb_wreg(a_wb_wreg), .wb_rn(a_wb_rn),
`ifdef MISALIGN_TRAP_EN
        .misalign_err(a_merr),
`endif
        .wb_result(a_wb_res)
    );

    mem_access_unit #(.DEPTH(256), .AW(8), .WAIT_CYCLES(2)) u2 (
        .clk(clk), .clr(clr),
        .mem_Alu_Result(b_addr), .mem_rb(b_rb), .mem_wmem(b_wmem),
        .mem_m2reg(b_m2reg), .mem_wreg(b_wreg), .mem_rn(b_rn),
        .stall(b_stall), .wb_Alu_Result(b_wb_alu), .wb_mem_data(b_wb_mdata),
        .wb_m2reg(b_wb_m2reg), .wb_wreg(b_wb_wreg), .wb_rn(b_wb_rn),
`ifdef MISALIGN_TRAP_EN
        .misalign_err(b_merr),
`endif
        .wb_result(b_wb_res)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] rb;
        logic        wmem;
        logic        m2reg;
        logic        wreg;
        logic [4:0]  rn;
        logic [31:0] e_alu;
        logic [31:0] e_mdata;
        logic        e_m2reg;
        logic        e_wreg;
        logic [4:0]  e_rn;
        logic [31:0] e_res;
    } vec_t;

    vec_t vt [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic b_drive(input logic [31:0] addr, input logic [31:0] rb,
                           input logic wmem, input logic m2reg, input logic wreg,
                           input logic [4:0] rn);
        b_addr = addr; b_rb = rb; b_wmem = wmem; b_m2reg = m2reg; b_wreg = wreg; b_rn = rn;
    endtask

    // Called right after inputs are driven on a falling edge. Counts stall
    // cycles up to completion, checking the bubble on each stalled edge.
    task automatic b_access(input string nm, input int exp_stalls);
        int n = 0;
        bit fin = 1'b0;
        for (int i = 0; i < 12 && !fin; i++) begin
            #1;
            if (b_stall) begin
                n++;
                @(posedge clk); #1;
                chk({nm, " bubble wreg"}, 32'(b_wb_wreg), 32'd0);
                @(negedge clk);
            end else begin
                fin = 1'b1;
                @(posedge clk); #1;
            end
        end
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL %s timeout stall never dropped", nm);
        end
        chk({nm, " stall cycles"}, 32'(n), 32'(exp_stalls));
    endtask

    initial begin
        //            addr          rb            wm m2 wr rn     e_alu         e_mdata       em ew ern   e_res
        vt[0] = '{32'h0000_1234, 32'h0,        0, 0, 1, 5'd3, 32'h0000_1234, 32'h0,        0, 1, 5'd3, 32'h0000_1234};
        vt[1] = '{32'h0000_0020, 32'hCAFEF00D, 1, 0, 0, 5'd0, 32'h0000_0020, 32'h0,        0, 0, 5'd0, 32'h0000_0020};
        vt[2] = '{32'h0000_0020, 32'h0,        0, 1, 1, 5'd5, 32'h0000_0020, 32'hCAFEF00D, 1, 1, 5'd5, 32'hCAFEF00D};
        vt[3] = '{32'h0000_0400, 32'h11223344, 1, 0, 0, 5'd0, 32'h0000_0400, 32'hCAFEF00D, 0, 0, 5'd0, 32'h0000_0400};
        vt[4] = '{32'h0000_0000, 32'h0,        0, 1, 1, 5'd6, 32'h0000_0000, 32'h11223344, 1, 1, 5'd6, 32'h11223344};
        vt[5] = '{32'h0000_0024, 32'h55AA55AA, 1, 1, 1, 5'd7, 32'h0000_0024, 32'h11223344, 0, 1, 5'd7, 32'h0000_0024};
        vt[6] = '{32'h0000_0024, 32'h0,        0, 1, 1, 5'd9, 32'h0000_0024, 32'h55AA55AA, 1, 1, 5'd9, 32'h55AA55AA};
        vt[7] = '{32'h0000_0424, 32'h0,        0, 1, 1, 5'd10, 32'h0000_0424, 32'h55AA55AA, 1, 1, 5'd10, 32'h55AA55AA};

        // Reset with a pending request on the waited instance.
        clr = 1'b1;
        a_addr = 0; a_rb = 0; a_wmem = 0; a_m2reg = 0; a_wreg = 0; a_rn = 0;
        b_drive(32'h10, 32'h0, 1'b0, 1'b1, 1'b1, 5'd1);
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("reset b stall", 32'(b_stall), 32'd0);
        chk("reset a wb_alu", a_wb_alu, 32'd0);
        chk("reset a wb_wreg", 32'(a_wb_wreg), 32'd0);
        chk("reset b wb_mdata", b_wb_mdata, 32'd0);
        chk("reset b wb_rn", 32'(b_wb_rn), 32'd0);
        chk("reset b wb_m2reg", 32'(b_wb_m2reg), 32'd0);
        clr = 1'b0;
        b_drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);

        // Zero-wait instance: table of single-cycle instructions.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a_addr = vt[i].addr; a_rb = vt[i].rb; a_wmem = vt[i].wmem;
            a_m2reg = vt[i].m2reg; a_wreg = vt[i].wreg; a_rn = vt[i].rn;
            #1;
            chk($sformatf("v%0d stall", i), 32'(a_stall), 32'd0);
            @(posedge clk); #1;
            chk($sformatf("v%0d wb_alu", i), a_wb_alu, vt[i].e_alu);
            chk($sformatf("v%0d wb_mdata", i), a_wb_mdata, vt[i].e_mdata);
            chk($sformatf("v%0d wb_m2reg", i), 32'(a_wb_m2reg), 32'(vt[i].e_m2reg));
            chk($sformatf("v%0d wb_wreg", i), 32'(a_wb_wreg), 32'(vt[i].e_wreg));
            chk($sformatf("v%0d wb_rn", i), 32'(a_wb_rn), 32'(vt[i].e_rn));
            chk($sformatf("v%0d wb_result", i), a_wb_res, vt[i].e_res);
        end
        @(negedge clk);
        a_addr = 0; a_rb = 0; a_wmem = 0; a_m2reg = 0; a_wreg = 0; a_rn = 0;

        // Two-wait instance: store then load.
        b_drive(32'h10, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 5'd0);
        b_access("st10", 2);
        @(negedge clk);
        b_drive(32'h10, 32'h0, 1'b0, 1'b1, 1'b1, 5'd8);
        b_access("ld10", 2);
        chk("ld10 wb_mdata", b_wb_mdata, 32'hDEADBEEF);
        chk("ld10 wb_result", b_wb_res, 32'hDEADBEEF);
        chk("ld10 wb_rn", 32'(b_wb_rn), 32'd8);
        chk("ld10 wb_wreg", 32'(b_wb_wreg), 32'd1);

        // ALU op right after completion: no stall, captured next edge.
        @(negedge clk);
        b_drive(32'h1234, 32'h0, 1'b0, 1'b0, 1'b1, 5'd3);
        #1;
        chk("alu stall", 32'(b_stall), 32'd0);
        @(posedge clk); #1;
        chk("alu wb_alu", b_wb_alu, 32'h1234);
        chk("alu wb_result", b_wb_res, 32'h1234);
        chk("alu wb_m2reg", 32'(b_wb_m2reg), 32'd0);

        // Old value at 0x30, then a store aborted by clr.
        @(negedge clk);
        b_drive(32'h30, 32'h0BADF00D, 1'b1, 1'b0, 1'b0, 5'd0);
        b_access("st30 old", 2);
        @(negedge clk);
        b_drive(32'h30, 32'h77777777, 1'b1, 1'b0, 1'b1, 5'd2);
        #1;
        chk("abort stall1", 32'(b_stall), 32'd1);
        @(negedge clk); #1;
        chk("abort stall2", 32'(b_stall), 32'd1);
        clr = 1'b1;
        #1;
        chk("abort stall under clr", 32'(b_stall), 32'd0);
        @(posedge clk); #1;
        chk("abort wb_alu", b_wb_alu, 32'd0);
        chk("abort wb_mdata", b_wb_mdata, 32'd0);
        chk("abort wb_rn", 32'(b_wb_rn), 32'd0);
        chk("abort wb_wreg", 32'(b_wb_wreg), 32'd0);
        @(negedge clk);
        clr = 1'b0;
        b_drive(32'h30, 32'h0, 1'b0, 1'b1, 1'b1, 5'd4);
        b_access("ld30", 2);
        chk("ld30 old value", b_wb_mdata, 32'h0BADF00D);
        chk("ld30 wb_result", b_wb_res, 32'h0BADF00D);

`ifdef MISALIGN_TRAP_EN
        // Misaligned load: immediate, trapped, no register write.
        @(negedge clk);
        b_drive(32'h13, 32'h0, 1'b0, 1'b1, 1'b1, 5'd8);
        #1;
        chk("mis ld stall", 32'(b_stall), 32'd0);
        @(posedge clk); #1;
        chk("mis ld err", 32'(b_merr), 32'd1);
        chk("mis ld wb_wreg", 32'(b_wb_wreg), 32'd0);
        // Misaligned store must not touch memory.
        @(negedge clk);
        b_drive(32'h13, 32'h99, 1'b1, 1'b0, 1'b0, 5'd0);
        #1;
        chk("mis st stall", 32'(b_stall), 32'd0);
        @(posedge clk); #1;
        chk("mis st err", 32'(b_merr), 32'd1);
        @(negedge clk);
        b_drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
        @(posedge clk); #1;
        chk("mis err clears", 32'(b_merr), 32'd0);
        @(negedge clk);
        b_drive(32'h10, 32'h0, 1'b0, 1'b1, 1'b1, 5'd8);
        b_access("ld10 after mis", 2);
        chk("mem unchanged", b_wb_mdata, 32'hDEADBEEF);
`endif

        @(negedge clk);
        b_drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0);
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
